// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC memory subsystem: requester indices,
// the mem_arb state encoding, default bus widths and a one-hot helper.
package sisc_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_LOAD  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_arb_state_t;

  // Index of the set bit in a 3-bit one-hot vector (0 when none is set).
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selector for mem_arb.
// Build option MEM_ARB_RR_EN: when defined, round-robin starting after the
// last-winner pointer; otherwise fixed priority data > fetch > loader.
module mem_arb_pick
  import sisc_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] win
);

`ifdef MEM_ARB_RR_EN
  // Rotating search beginning at ptr+1 mod 3.
  always_comb begin
    win = 3'b000;
    case (ptr)
      2'd0: begin
        if      (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      2'd1: begin
        if      (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if      (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
  end
`else
  // The pointer only matters in the round-robin build.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Fixed priority: data beats fetch beats loader.
  always_comb begin
    win = 3'b000;
    if      (req[REQ_DATA])  win[REQ_DATA]  = 1'b1;
    else if (req[REQ_FETCH]) win[REQ_FETCH] = 1'b1;
    else if (req[REQ_LOAD])  win[REQ_LOAD]  = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_arb.sv
// Three-way arbiter and sequencer for the single-port SISC memory.
// IDLE arbitrates and latches the winner's request, ACCESS drives the memory
// for WAIT+1 cycles, DONE pulses the winner's ack. Arbitration policy comes
// from mem_arb_pick (MEM_ARB_RR_EN selects round-robin there).
//
// Handshake: a requester raises req[i] with we/addr/wdata stable and holds
// them until ack[i] pulses for one cycle; gnt[i] is high during ACCESS only.
// Dropping req after the grant does not abort the access.
module mem_arb
  import sisc_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int WAIT = 1
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  mem_arb_state_t state_q, state_d;
  logic [2:0]    win_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [2:0]    cnt_q;
  logic [1:0]    ptr_q;

  logic [2:0]    pick_win;
  logic          pick_we;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;
  logic          take;

  mem_arb_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win)
  );

  assign take = (state_q == ST_IDLE) && (req != 3'b000);

  // Route the winning requester's fields to the capture registers.
  always_comb begin
    pick_we    = we[REQ_FETCH];
    pick_addr  = addr[REQ_FETCH*AW +: AW];
    pick_wdata = wdata[REQ_FETCH*DW +: DW];
    if (pick_win[REQ_DATA]) begin
      pick_we    = we[REQ_DATA];
      pick_addr  = addr[REQ_DATA*AW +: AW];
      pick_wdata = wdata[REQ_DATA*DW +: DW];
    end else if (pick_win[REQ_LOAD]) begin
      pick_we    = we[REQ_LOAD];
      pick_addr  = addr[REQ_LOAD*AW +: AW];
      pick_wdata = wdata[REQ_LOAD*DW +: DW];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req != 3'b000) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == 3'd0) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Transaction latches, wait counter, read capture and last-winner pointer.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      win_q   <= 3'b000;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 3'd0;
      ptr_q   <= 2'd2;
    end else if (take) begin
      win_q   <= pick_win;
      we_q    <= pick_we;
      addr_q  <= pick_addr;
      wdata_q <= pick_wdata;
      cnt_q   <= WAIT_CNT;
      ptr_q   <= onehot_to_idx(pick_win);
    end else if (state_q == ST_ACCESS) begin
      if (cnt_q == 3'd0) begin
        if (!we_q) rdata_q <= mem_rdata;
      end else begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  // Outputs decoded from state; address/data hold their last latched value.
  always_comb begin
    gnt    = 3'b000;
    ack    = 3'b000;
    mem_en = 1'b0;
    mem_we = 1'b0;
    busy   = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        gnt    = win_q;
        mem_en = 1'b1;
        mem_we = we_q;
        busy   = 1'b1;
      end
      ST_DONE: begin
        ack  = win_q;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb. Three instances share the requester fields:
// dut1 (WAIT=1) carries most scenarios, dut0 (WAIT=0) and dut7 (WAIT=7)
// cover the latency extremes. A small memory model answers reads.
module tb_mem_arb;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk;
  logic          rst_f;
  logic [2:0]    req, req0, req7;
  logic [2:0]    we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;

  logic [2:0]    gnt1, ack1, gnt0, ack0, gnt7, ack7;
  logic [DW-1:0] rdata1, rdata0, rdata7;
  logic          mem_en1, mem_we1, busy1, mem_en0, mem_we0, busy0, mem_en7, mem_we7, busy7;
  logic [AW-1:0] mem_addr1, mem_addr0, mem_addr7;
  logic [DW-1:0] mem_wdata1, mem_wdata0, mem_wdata7;
  logic [DW-1:0] mem_rdata1, mem_rdata0, mem_rdata7;
  logic [1:0]    st1, st0, st7;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [0:255];
  bit            mem_vld [0:255];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 16'h0010) return 32'h12345678;
    if (a == 16'h0030) return 32'hA5A50030;
    return {16'hC0DE, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en1 && mem_we1) begin
      mem[mem_addr1[7:0]]     <= mem_wdata1;
      mem_vld[mem_addr1[7:0]] <= 1'b1;
    end
  end

  assign mem_rdata1 = mem_vld[mem_addr1[7:0]] ? mem[mem_addr1[7:0]] : init_val(mem_addr1);
  assign mem_rdata0 = init_val(mem_addr0);
  assign mem_rdata7 = init_val(mem_addr7);

  mem_arb #(.AW(AW), .DW(DW), .WAIT(1)) dut1 (
    .clk(clk), .rst_f(rst_f), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt1), .ack(ack1), .rdata(rdata1), .mem_en(mem_en1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .busy(busy1), .state_dbg(st1)
  );

  mem_arb #(.AW(AW), .DW(DW), .WAIT(0)) dut0 (
    .clk(clk), .rst_f(rst_f), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt0), .ack(ack0), .rdata(rdata0), .mem_en(mem_en0), .mem_we(mem_we0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
    .busy(busy0), .state_dbg(st0)
  );

  mem_arb #(.AW(AW), .DW(DW), .WAIT(7)) dut7 (
    .clk(clk), .rst_f(rst_f), .req(req7), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt7), .ack(ack7), .rdata(rdata7), .mem_en(mem_en7), .mem_we(mem_we7),
    .mem_addr(mem_addr7), .mem_wdata(mem_wdata7), .mem_rdata(mem_rdata7),
    .busy(busy7), .state_dbg(st7)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i]            = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic pulse_reset();
    #1 rst_f = 1'b0;
    #3 rst_f = 1'b1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_f = 1'b0;
    #12;
    n_vec++;
    if ({gnt1, ack1, busy1, mem_en1, mem_we1, st1} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: gnt=%b ack=%b busy=%b en=%b we=%b st=%0d, required all 0",
               gnt1, ack1, busy1, mem_en1, mem_we1, st1);
    end
    n_vec++;
    if ({rdata1, mem_addr1, mem_wdata1} !== '0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, required 0", rdata1, mem_addr1, mem_wdata1);
    end
    rst_f = 1'b1;
    tick();
  endtask

  task automatic test_fetch_read();
    set_req(0, 1'b0, 16'h0010, 32'h0);
    req = 3'b001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_vec++;
      if (c < 3) begin
        if (gnt1 !== 3'b001 || mem_en1 !== 1'b1 || mem_we1 !== 1'b0 || mem_addr1 !== 16'h0010 || ack1 !== 3'b000) begin
          n_err++;
          $display("FAIL fetch_access c%0d: gnt=%b en=%b we=%b addr=%h ack=%b, required 001/1/0/0010/000",
                   c, gnt1, mem_en1, mem_we1, mem_addr1, ack1);
        end
      end else begin
        if (ack1 !== 3'b001 || gnt1 !== 3'b000 || rdata1 !== 32'h12345678 || mem_we1 !== 1'b0) begin
          n_err++;
          $display("FAIL fetch_ack: ack=%b gnt=%b rdata=%h we=%b, required 001/000/12345678/0",
                   ack1, gnt1, rdata1, mem_we1);
        end
      end
    end
    req = 3'b000;
    tick();
    n_vec++;
    if (ack1 !== 3'b000 || busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_after: ack=%b busy=%b, required 000/0", ack1, busy1);
    end
  endtask

  task automatic test_write_then_read();
    set_req(1, 1'b1, 16'h0020, 32'hDEADBEEF);
    req = 3'b010;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_vec++;
      if (c < 3) begin
        if (gnt1 !== 3'b010 || mem_we1 !== 1'b1 || mem_wdata1 !== 32'hDEADBEEF || mem_addr1 !== 16'h0020) begin
          n_err++;
          $display("FAIL write_access c%0d: gnt=%b we=%b wdata=%h addr=%h, required 010/1/deadbeef/0020",
                   c, gnt1, mem_we1, mem_wdata1, mem_addr1);
        end
      end else begin
        if (ack1 !== 3'b010 || mem_we1 !== 1'b0 || rdata1 !== 32'h12345678) begin
          n_err++;
          $display("FAIL write_ack: ack=%b we=%b rdata=%h, required 010/0/12345678", ack1, mem_we1, rdata1);
        end
      end
    end
    req = 3'b000;
    set_req(1, 1'b0, 16'h0000, 32'h0);
    tick();
    n_vec++;
    if (mem[8'h20] !== 32'hDEADBEEF || mem_we1 !== 1'b0 || mem_en1 !== 1'b0 || mem_addr1 !== 16'h0020) begin
      n_err++;
      $display("FAIL write_mem: mem=%h we=%b en=%b addr=%h, required deadbeef/0/0/0020 (held)",
               mem[8'h20], mem_we1, mem_en1, mem_addr1);
    end
    set_req(0, 1'b0, 16'h0020, 32'h0);
    req = 3'b001;
    tick();
    n_vec++;
    if (gnt1 !== 3'b001 || mem_we1 !== 1'b0) begin
      n_err++;
      $display("FAIL readback_grant: gnt=%b we=%b, required 001/0", gnt1, mem_we1);
    end
    tick();
    tick();
    n_vec++;
    if (ack1 !== 3'b001 || rdata1 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL readback_ack: ack=%b rdata=%h, required 001/deadbeef", ack1, rdata1);
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_priority();
    logic [2:0] exp_q[$];
    logic [2:0] e;
    pulse_reset();
    set_req(0, 1'b0, 16'h0040, 32'h0);
    set_req(1, 1'b0, 16'h0041, 32'h0);
    set_req(2, 1'b0, 16'h0042, 32'h0);
`ifdef MEM_ARB_RR_EN
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(3'b010);
`endif
    req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      e = exp_q.pop_front();
      tick();
      n_vec++;
      if (gnt1 !== e) begin
        n_err++;
        $display("FAIL prio_gnt t%0d: gnt=%b, required %b", t, gnt1, e);
      end
      tick();
      tick();
      n_vec++;
      if (ack1 !== e || gnt1 !== 3'b000) begin
        n_err++;
        $display("FAIL prio_ack t%0d: ack=%b gnt=%b, required %b/000", t, ack1, gnt1, e);
      end
      tick();
    end
    req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_access();
    set_req(1, 1'b0, 16'h0010, 32'h0);
    req = 3'b010;
    tick();
    n_vec++;
    if (gnt1 !== 3'b010 || busy1 !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: gnt=%b busy=%b, required 010/1", gnt1, busy1);
    end
    #1 rst_f = 1'b0;
    #1;
    n_vec++;
    if ({gnt1, ack1, busy1, mem_en1, mem_we1, rdata1, mem_addr1, mem_wdata1} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outs: gnt=%b ack=%b busy=%b en=%b rdata=%h addr=%h, required all 0",
               gnt1, ack1, busy1, mem_en1, rdata1, mem_addr1);
    end
    req = 3'b000;
    #10 rst_f = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (ack1 !== 3'b000 || busy1 !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_noack c%0d: ack=%b busy=%b, required 000/0", c, ack1, busy1);
      end
    end
    req = 3'b010;
    tick();
    n_vec++;
    if (gnt1 !== 3'b010) begin
      n_err++;
      $display("FAIL rst_mid_regrant: gnt=%b, required 010", gnt1);
    end
    tick();
    tick();
    n_vec++;
    if (ack1 !== 3'b010 || rdata1 !== 32'h12345678) begin
      n_err++;
      $display("FAIL rst_mid_reack: ack=%b rdata=%h, required 010/12345678", ack1, rdata1);
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_wait_extremes();
    set_req(2, 1'b0, 16'h0030, 32'h0);
    req0 = 3'b100;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_vec++;
      if (busy0 !== (c <= 2) || ack0 !== ((c == 2) ? 3'b100 : 3'b000)) begin
        n_err++;
        $display("FAIL wait0 c%0d: busy=%b ack=%b", c, busy0, ack0);
      end
      if (c == 2) begin
        n_vec++;
        if (rdata0 !== 32'hA5A50030) begin
          n_err++;
          $display("FAIL wait0_rdata: rdata=%h, required a5a50030", rdata0);
        end
        req0 = 3'b000;
      end
    end
    req7 = 3'b100;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_vec++;
      if (busy7 !== (c <= 9) || ack7 !== ((c == 9) ? 3'b100 : 3'b000)) begin
        n_err++;
        $display("FAIL wait7 c%0d: busy=%b ack=%b", c, busy7, ack7);
      end
      if (c == 9) begin
        n_vec++;
        if (rdata7 !== 32'hA5A50030) begin
          n_err++;
          $display("FAIL wait7_rdata: rdata=%h, required a5a50030", rdata7);
        end
        req7 = 3'b000;
      end
    end
  endtask

  task automatic test_req_drop();
    set_req(0, 1'b0, 16'h0010, 32'h0);
    req = 3'b001;
    tick();
    n_vec++;
    if (gnt1 !== 3'b001) begin
      n_err++;
      $display("FAIL drop_gnt: gnt=%b, required 001", gnt1);
    end
    req = 3'b000;
    tick();
    tick();
    n_vec++;
    if (ack1 !== 3'b001 || rdata1 !== 32'h12345678) begin
      n_err++;
      $display("FAIL drop_ack: ack=%b rdata=%h, required 001/12345678", ack1, rdata1);
    end
    for (int c = 4; c <= 6; c++) begin
      tick();
      n_vec++;
      if (gnt1 !== 3'b000 || ack1 !== 3'b000 || busy1 !== 1'b0) begin
        n_err++;
        $display("FAIL drop_idle c%0d: gnt=%b ack=%b busy=%b, required 000/000/0", c, gnt1, ack1, busy1);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    req   = 3'b000;
    req0  = 3'b000;
    req7  = 3'b000;
    we    = 3'b000;
    addr  = '0;
    wdata = '0;
    test_reset();
    test_fetch_read();
    test_write_then_read();
    test_priority();
    test_reset_mid_access();
    test_wait_extremes();
    test_req_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
